// File: rtl/compound_rr_arbiter_pkg.sv
// Shared types for the compound round-robin arbiter.
//   CompoundType   : payload carried on every sync/notify channel {mode, x, y}
//   COMPOUND_RESET : payload value held on arb_out while in reset
//   ArbSections    : section encoding of the arbiter FSM
package compound_arb_types;

   typedef enum logic {
      MODE_READ  = 1'b0,
      MODE_WRITE = 1'b1
   } CompoundMode;

   typedef struct packed {
      CompoundMode mode;
      logic [31:0] x;
      logic [31:0] y;
   } CompoundType;

   localparam CompoundType COMPOUND_RESET = '{mode: MODE_READ, x: 32'd0, y: 32'd0};

   typedef enum logic [1:0] {
      SEC_IDLE   = 2'd0,
      SEC_ACCEPT = 2'd1,
      SEC_SEND   = 2'd2
   } ArbSections;

endpackage

// File: rtl/compound_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_req    : request vector, one bit per requester
//   i_ptr    : index given highest priority (must be < NUM_REQ)
//   o_valid  : at least one request is set
//   o_winner : first set index scanning i_ptr, i_ptr+1, ... mod NUM_REQ
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic               o_valid,
   output logic [IDW-1:0]     o_winner
);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   logic [IDW-1:0]       w_off;
   logic [IDW:0]         w_sum;

   // Rotating the doubled vector puts requester (ptr+k) mod NUM_REQ at bit k,
   // so a plain lowest-bit priority encode gives the round-robin offset.
   assign w_dbl = {i_req, i_req} >> i_ptr;
   assign w_rot = w_dbl[NUM_REQ-1:0];

   always_comb begin
      o_valid = 1'b0;
      w_off   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_valid = 1'b1;
            w_off   = IDW'(k);
         end
      end
   end

   // Explicit modulo so a non-power-of-2 NUM_REQ never yields an index >= NUM_REQ.
   always_comb begin
      w_sum = {1'b0, i_ptr} + {1'b0, w_off};
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
         w_sum = w_sum - (IDW+1)'(NUM_REQ);
      end
      o_winner = w_sum[IDW-1:0];
   end

endmodule

// File: rtl/compound_rr_arbiter.sv
// Round-robin arbiter sharing one CompoundType output channel between
// NUM_REQ requesters, all using the sync (peer ready) / notify (we offer)
// handshake; a transfer happens on a rising clk edge with both high.
//   clk, rst        : clock, async active-low reset
//   req_in          : per-requester payload
//   req_in_sync     : requester i holds valid payload
//   req_in_notify   : arbiter accepts from requester i (at most one bit high)
//   arb_out         : forwarded payload, stable while arb_out_notify is high
//   arb_out_sync    : consumer ready
//   arb_out_notify  : arbiter offers arb_out
//   grant_id        : index of the currently granted requester
//   xfer_count      : completed output transfers, wraps silently
//
// section    | meaning
// SEC_IDLE   | no notify high; pick next requester round-robin from rr_ptr
// SEC_ACCEPT | notify to granted requester; latch payload if it still syncs
// SEC_SEND   | offer latched payload to consumer until it syncs
module compound_rr_arbiter
   import compound_arb_types::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  CompoundType [NUM_REQ-1:0] req_in,
   input  logic [NUM_REQ-1:0]        req_in_sync,
   output logic [NUM_REQ-1:0]        req_in_notify,
   output CompoundType               arb_out,
   input  logic                      arb_out_sync,
   output logic                      arb_out_notify,
   output logic [IDW-1:0]            grant_id,
   output logic [31:0]               xfer_count
);

   localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

   ArbSections         r_sec;
   logic [NUM_REQ-1:0] r_req_notify;
   CompoundType        r_arb_out;
   logic               r_arb_notify;
   logic [IDW-1:0]     r_grant_id;
   logic [IDW-1:0]     r_rr_ptr;
   logic [31:0]        r_xfer_count;

   logic               w_valid;
   logic [IDW-1:0]     w_winner;
   logic [IDW-1:0]     w_ptr_next;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_pick (
      .i_req    (req_in_sync),
      .i_ptr    (r_rr_ptr),
      .o_valid  (w_valid),
      .o_winner (w_winner)
   );

   assign w_ptr_next = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sec        <= SEC_IDLE;
         r_req_notify <= '0;
         r_arb_out    <= COMPOUND_RESET;
         r_arb_notify <= 1'b0;
         r_grant_id   <= '0;
         r_rr_ptr     <= '0;
         r_xfer_count <= '0;
      end else begin
         case (r_sec)
            SEC_IDLE: begin
               if (w_valid) begin
                  r_grant_id   <= w_winner;
                  r_req_notify <= REQ_ONE << w_winner;
                  r_sec        <= SEC_ACCEPT;
               end
            end
            SEC_ACCEPT: begin
               r_req_notify <= '0;
               if (req_in_sync[r_grant_id]) begin
                  r_arb_out    <= req_in[r_grant_id];
                  r_arb_notify <= 1'b1;
                  r_sec        <= SEC_SEND;
               end else begin
                  // Withdrawn request: rr_ptr untouched so the same requester
                  // keeps priority when it asks again.
                  r_sec <= SEC_IDLE;
               end
            end
            SEC_SEND: begin
               if (arb_out_sync) begin
                  r_arb_notify <= 1'b0;
                  r_rr_ptr     <= w_ptr_next;
                  r_xfer_count <= r_xfer_count + 32'd1;
                  r_sec        <= SEC_IDLE;
               end
            end
            default: begin
               r_sec        <= SEC_IDLE;
               r_req_notify <= '0;
               r_arb_notify <= 1'b0;
            end
         endcase
      end
   end

   assign req_in_notify  = r_req_notify;
   assign arb_out        = r_arb_out;
   assign arb_out_notify = r_arb_notify;
   assign grant_id       = r_grant_id;
   assign xfer_count     = r_xfer_count;

endmodule

// File: tb/tb_compound_rr_arbiter.sv
module tb_compound_rr_arbiter;
   import compound_arb_types::*;

   localparam int N = 4;

   logic                clk = 1'b0;
   logic                rst;
   CompoundType [N-1:0] req_in;
   logic [N-1:0]        req_in_sync;
   logic [N-1:0]        req_in_notify;
   CompoundType         arb_out;
   logic                arb_out_sync;
   logic                arb_out_notify;
   logic [1:0]          grant_id;
   logic [31:0]         xfer_count;

   typedef struct packed {
      CompoundType data;
      logic [1:0]  id;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   compound_rr_arbiter #(.NUM_REQ(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_in         (req_in),
      .req_in_sync    (req_in_sync),
      .req_in_notify  (req_in_notify),
      .arb_out        (arb_out),
      .arb_out_sync   (arb_out_sync),
      .arb_out_notify (arb_out_notify),
      .grant_id       (grant_id),
      .xfer_count     (xfer_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic CompoundType mkpay(input int i);
      CompoundType p;
      logic [31:0] v;
      v      = 32'h1111_1111 * i;
      p.mode = (i % 2 == 1) ? MODE_WRITE : MODE_READ;
      p.x    = v;
      p.y    = ~v;
      return p;
   endfunction

   // Inputs change at posedge+2; everything sampled here is what the next edge sees.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Monitor: one-notify invariant every cycle, scoreboard pop on each output transfer.
   always @(negedge clk) begin
      int   n_hi;
      exp_t e;
      n_hi = $countones({req_in_notify, arb_out_notify});
      chk("single_notify", 65'(n_hi <= 1), 65'd1);
      if (rst === 1'b1 && arb_out_notify === 1'b1 && arb_out_sync === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_xfer: got payload %0h id %0d expected no transfer at %0t",
                     arb_out, grant_id, $time);
         end else begin
            e = sb_q.pop_front();
            chk("xfer_data", 65'(arb_out), 65'(e.data));
            chk("xfer_id", 65'(grant_id), 65'(e.id));
         end
      end
   end

   localparam CompoundType P2 = '{mode: MODE_WRITE, x: 32'h1234_5678, y: 32'h9ABC_DEF0};
   localparam CompoundType PW = '{mode: MODE_WRITE, x: 32'h7FFF_FFFF, y: 32'd1};

   initial begin
      rst          = 1'b0;
      req_in       = '0;
      req_in_sync  = '0;
      arb_out_sync = 1'b0;
      repeat (2) tick();
      chk("rst_req_notify", 65'(req_in_notify), 65'd0);
      chk("rst_arb_notify", 65'(arb_out_notify), 65'd0);
      chk("rst_arb_out", 65'(arb_out), 65'(COMPOUND_RESET));
      chk("rst_grant", 65'(grant_id), 65'd0);
      chk("rst_xfer", 65'(xfer_count), 65'd0);
      rst = 1'b1;
      tick();

      // single requester 2
      req_in[2]    = P2;
      req_in_sync  = 4'b0100;
      arb_out_sync = 1'b1;
      sb_q.push_back('{data: P2, id: 2'd2});
      tick();
      chk("t1_notify", 65'(req_in_notify), 65'b0100);
      chk("t1_grant", 65'(grant_id), 65'd2);
      chk("t1_arb_notify_lo", 65'(arb_out_notify), 65'd0);
      tick();
      chk("t1_arb_notify_hi", 65'(arb_out_notify), 65'd1);
      chk("t1_notify_drop", 65'(req_in_notify), 65'd0);
      chk("t1_arb_out", 65'(arb_out), 65'(P2));
      req_in_sync = '0;
      tick();
      chk("t1_xfer", 65'(xfer_count), 65'd1);
      chk("t1_arb_notify_end", 65'(arb_out_notify), 65'd0);
      chk("t1_grant_end", 65'(grant_id), 65'd2);

      // all four requesting, consumer always ready, from reset
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < N; i++) req_in[i] = mkpay(i);
      for (int r = 0; r < 8; r++) sb_q.push_back('{data: mkpay(r % N), id: 2'(r % N)});
      req_in_sync = 4'b1111;
      repeat (23) tick();
      chk("t2_xfer_23", 65'(xfer_count), 65'd7);
      tick();
      chk("t2_xfer_24", 65'(xfer_count), 65'd8);
      req_in_sync = '0;

      // requester 0 once to move rr_ptr to 1, then requester 1 withdraws in ACCEPT
      req_in_sync = 4'b0001;
      sb_q.push_back('{data: mkpay(0), id: 2'd0});
      tick();
      tick();
      req_in_sync = '0;
      tick();
      chk("t3_xfer_pre", 65'(xfer_count), 65'd9);
      req_in_sync = 4'b0010;
      tick();
      chk("t3_notify1", 65'(req_in_notify), 65'b0010);
      chk("t3_grant1", 65'(grant_id), 65'd1);
      req_in_sync = '0;
      tick();
      chk("t3_withdraw_notify", 65'(req_in_notify), 65'd0);
      chk("t3_withdraw_arb", 65'(arb_out_notify), 65'd0);
      tick();
      chk("t3_xfer_same", 65'(xfer_count), 65'd9);
      chk("t3_rr_ptr", 65'(dut.r_rr_ptr), 65'd1);
      req_in_sync = 4'b0111;
      sb_q.push_back('{data: mkpay(1), id: 2'd1});
      tick();
      chk("t3_regrant", 65'(grant_id), 65'd1);
      chk("t3_regrant_notify", 65'(req_in_notify), 65'b0010);
      tick();
      req_in_sync = '0;
      tick();
      chk("t3_xfer_post", 65'(xfer_count), 65'd10);

      // consumer stalls 10 cycles in SEND; new requests must be ignored
      req_in_sync  = 4'b1000;
      arb_out_sync = 1'b0;
      sb_q.push_back('{data: mkpay(3), id: 2'd3});
      tick();
      tick();
      req_in_sync = 4'b1111;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("t4_stall_notify", 65'(arb_out_notify), 65'd1);
         chk("t4_stall_data", 65'(arb_out), 65'(mkpay(3)));
         chk("t4_stall_req_notify", 65'(req_in_notify), 65'd0);
      end
      arb_out_sync = 1'b1;
      req_in_sync  = '0;
      tick();
      chk("t4_xfer", 65'(xfer_count), 65'd11);
      chk("t4_arb_notify_end", 65'(arb_out_notify), 65'd0);

      // reset while holding a latched payload in SEND
      req_in[0]    = PW;
      req_in_sync  = 4'b0001;
      arb_out_sync = 1'b0;
      tick();
      tick();
      req_in_sync = '0;
      chk("t5_send_notify", 65'(arb_out_notify), 65'd1);
      chk("t5_send_data", 65'(arb_out), 65'(PW));
      #1 rst = 1'b0;
      #1;
      chk("t5_async_arb_notify", 65'(arb_out_notify), 65'd0);
      chk("t5_async_arb_out", 65'(arb_out), 65'(COMPOUND_RESET));
      chk("t5_async_xfer", 65'(xfer_count), 65'd0);
      chk("t5_async_grant", 65'(grant_id), 65'd0);
      chk("t5_async_req_notify", 65'(req_in_notify), 65'd0);
      tick();
      rst          = 1'b1;
      arb_out_sync = 1'b1;
      repeat (6) tick();
      chk("t5_post_arb_notify", 65'(arb_out_notify), 65'd0);
      chk("t5_post_xfer", 65'(xfer_count), 65'd0);
      chk("t5_post_arb_out", 65'(arb_out), 65'(COMPOUND_RESET));

      // xfer_count wrap
      force dut.r_xfer_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_xfer_count;
      chk("t6_preload", 65'(xfer_count), 65'hFFFF_FFFF);
      req_in[2]   = P2;
      req_in_sync = 4'b0100;
      sb_q.push_back('{data: P2, id: 2'd2});
      tick();
      tick();
      req_in_sync = '0;
      tick();
      chk("t6_wrap", 65'(xfer_count), 65'd0);
      chk("t6_grant", 65'(grant_id), 65'd2);
      chk("t6_arb_out", 65'(arb_out), 65'(P2));
      chk("t6_arb_notify", 65'(arb_out_notify), 65'd0);
      chk("t6_rr_ptr", 65'(dut.r_rr_ptr), 65'd3);

      repeat (2) tick();
      chk("sb_drained", 65'(sb_q.size()), 65'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
